// File: rtl/i3c_bus_param.sv
// ---------------------------------------------------------------------------
// i3c_bus_param
//
// Bus-clocked, full-duplex serial slave. A start bit (bus_din=1 while idle)
// opens a frame. Each word shifts DATA_W bits in on bus_din and out on
// bus_dout, MSB first, optionally followed by an even-parity bit, and always
// by a continuation bit (1 = another word follows, 0 = frame ends).
//
// Ports
//   bus_clk        bus clock, all logic on its rising edge
//   bus_rst_n      synchronous active-low reset
//   bus_din        serial data from master
//   bus_dout       serial data to master (registered)
//   parallel_din   transmit word, captured on the edge that raises tx_load
//   parallel_dout  last received word, held until the next word
//   data_ready     one-cycle strobe: parallel_dout was just updated
//   parity_err     parity result of the word just delivered, held
//   tx_load        one-cycle strobe: parallel_din was just captured
//   word_cnt       words completed in the current frame, saturating
//   dbg_state      0 IDLE, 1 SHIFT, 2 PAR, 3 CONT
// ---------------------------------------------------------------------------
module i3c_bus_param #(
    parameter int DATA_W    = 16,
    parameter int PARITY_EN = 1,
    parameter int CNT_W     = 8
) (
    input  logic              bus_clk,
    input  logic              bus_rst_n,
    input  logic              bus_din,
    output logic              bus_dout,
    input  logic [DATA_W-1:0] parallel_din,
    output logic [DATA_W-1:0] parallel_dout,
    output logic              data_ready,
    output logic              parity_err,
    output logic              tx_load,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_CONT  = 2'd3
    } state_t;

    localparam int              BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t              state_q,    state_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]   rx_word_q,  rx_word_d;
    logic [BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic                tx_par_q,   tx_par_d;
    logic                dout_q,     dout_d;
    logic                ready_q,    ready_d;
    logic                perr_q,     perr_d;
    logic                load_q,     load_d;

    logic                deliver;
    logic [DATA_W-1:0]   deliver_word;
    logic                deliver_perr;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        rx_word_d    = rx_word_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        tx_par_d     = tx_par_q;
        perr_d       = perr_q;
        ready_d      = 1'b0;
        load_d       = 1'b0;
        deliver      = 1'b0;
        deliver_word = rx_shift_q;
        deliver_perr = 1'b0;
        dout_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus_din) begin
                    load_d     = 1'b1;
                    word_cnt_d = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                rx_shift_d = {rx_shift_q[DATA_W-2:0], bus_din};
                tx_shift_d = tx_shift_q << 1;
                bit_cnt_d  = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    if (PARITY_EN != 0) begin
                        state_d = ST_PAR;
                    end else begin
                        // Without a parity phase the last data edge delivers,
                        // so the word includes the bit being sampled now.
                        state_d      = ST_CONT;
                        deliver      = 1'b1;
                        deliver_word = rx_shift_d;
                    end
                end
            end
            ST_PAR: begin
                // Even parity: XOR over word plus parity bit must be 0.
                state_d      = ST_CONT;
                deliver      = 1'b1;
                deliver_word = rx_shift_q;
                deliver_perr = (^rx_shift_q) ^ bus_din;
            end
            ST_CONT: begin
                if (bus_din) begin
                    load_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (load_d) begin
            tx_shift_d = parallel_din;
            tx_par_d   = ^parallel_din;
            bit_cnt_d  = '0;
        end

        if (deliver) begin
            rx_word_d = deliver_word;
            perr_d    = deliver_perr;
            ready_d   = 1'b1;
            if (word_cnt_q != CNT_MAX) begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end

        // bus_dout is registered from next-state values so the pin shows
        // the same bit the state machine will be in for the whole cycle.
        unique case (state_d)
            ST_SHIFT: dout_d = tx_shift_d[DATA_W-1];
            ST_PAR:   dout_d = tx_par_d;
            default:  dout_d = 1'b0;
        endcase
    end

    // NOTE: reset is sampled on the clock edge (synchronous), and all state
    // updates use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            state_q    <= ST_IDLE;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_word_q  <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            tx_par_q   <= 1'b0;
            dout_q     <= 1'b0;
            ready_q    <= 1'b0;
            perr_q     <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            rx_word_q  <= rx_word_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            tx_par_q   <= tx_par_d;
            dout_q     <= dout_d;
            ready_q    <= ready_d;
            perr_q     <= perr_d;
            load_q     <= load_d;
        end
    end

    assign bus_dout      = dout_q;
    assign parallel_dout = rx_word_q;
    assign data_ready    = ready_q;
    assign parity_err    = perr_q;
    assign tx_load       = load_q;
    assign word_cnt      = word_cnt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_i3c_bus_param.sv
// ---------------------------------------------------------------------------
// tb_i3c_bus_param
//
// Two instances: u_p (DATA_W=16, parity, CNT_W=8) and u_n (DATA_W=8, no
// parity, CNT_W=2). A table of words drives frames through either instance
// and checks every output on every cycle; hand sequences cover reset during
// a frame and idle noise.
// ---------------------------------------------------------------------------
module tb_i3c_bus_param;

    logic        clk = 1'b0;
    logic        bus_rst_n = 1'b0;
    logic        din_drv = 1'b0;
    logic [15:0] pdin_drv = 16'h0000;
    logic        cur = 1'b0;

    logic        din_p, dout_p, rdy_p, perr_p, txl_p;
    logic [15:0] pdout_p;
    logic [7:0]  cnt_p;
    logic [1:0]  st_p;

    logic        din_n, dout_n, rdy_n, perr_n, txl_n;
    logic [7:0]  pdin_n, pdout_n;
    logic [1:0]  cnt_n;
    logic [1:0]  st_n;

    always #5 clk = ~clk;

    assign din_p  = (cur == 1'b0) ? din_drv : 1'b0;
    assign din_n  = (cur == 1'b1) ? din_drv : 1'b0;
    assign pdin_n = pdin_drv[7:0];

    i3c_bus_param #(.DATA_W(16), .PARITY_EN(1), .CNT_W(8)) u_p (
        .bus_clk(clk), .bus_rst_n(bus_rst_n), .bus_din(din_p), .bus_dout(dout_p),
        .parallel_din(pdin_drv), .parallel_dout(pdout_p), .data_ready(rdy_p),
        .parity_err(perr_p), .tx_load(txl_p), .word_cnt(cnt_p), .dbg_state(st_p)
    );

    i3c_bus_param #(.DATA_W(8), .PARITY_EN(0), .CNT_W(2)) u_n (
        .bus_clk(clk), .bus_rst_n(bus_rst_n), .bus_din(din_n), .bus_dout(dout_n),
        .parallel_din(pdin_n), .parallel_dout(pdout_n), .data_ready(rdy_n),
        .parity_err(perr_n), .tx_load(txl_n), .word_cnt(cnt_n), .dbg_state(st_n)
    );

    // Outputs of whichever instance is currently under test.
    logic        o_dout, o_rdy, o_perr, o_txl;
    logic [15:0] o_pdout;
    logic [7:0]  o_cnt;
    logic [1:0]  o_st;
    assign o_dout  = cur ? dout_n : dout_p;
    assign o_rdy   = cur ? rdy_n  : rdy_p;
    assign o_perr  = cur ? perr_n : perr_p;
    assign o_txl   = cur ? txl_n  : txl_p;
    assign o_pdout = cur ? {8'h00, pdout_n} : pdout_p;
    assign o_cnt   = cur ? {6'b0, cnt_n} : cnt_p;
    assign o_st    = cur ? st_n : st_p;

    typedef struct {
        bit          sel;      // 0 = u_p, 1 = u_n
        logic [15:0] tx;       // parallel_din for this word
        logic [15:0] rx;       // word sent on bus_din, expected on parallel_dout
        logic        par_bit;  // parity bit sent (u_p only)
        logic        cont;     // continuation bit
        logic        txpar;    // expected bus_dout during PAR
        logic        perr;     // expected parity_err
        logic [7:0]  cnt;      // expected word_cnt after delivery
    } vec_t;

    vec_t        tbl [12];
    logic [15:0] last_dout [2];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input int s);
        cur = (s != 0);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout"},  o_dout,  0);
        check({tag, "_pdout"}, o_pdout, 0);
        check({tag, "_ready"}, o_rdy,   0);
        check({tag, "_perr"},  o_perr,  0);
        check({tag, "_load"},  o_txl,   0);
        check({tag, "_cnt"},   o_cnt,   0);
        check({tag, "_state"}, o_st,    0);
    endtask

    // One word: load edge (start or continuation), data bits, optional
    // parity, then the frame-ending continuation bit if cont=0.
    task automatic run_word(input vec_t v, input bit first);
        int w;
        w = v.sel ? 8 : 16;
        if (first) select(int'(v.sel));
        pdin_drv = v.tx;
        din_drv  = 1'b1;
        tick();
        check("tx_load_pulse", o_txl, 1);
        check("state_shift", o_st, 1);
        check("ready_low_at_load", o_rdy, 0);
        if (first) check("cnt_cleared", o_cnt, 0);
        for (int k = w - 1; k >= 0; k--) begin
            check("tx_bit", o_dout, v.tx[k]);
            check("word_held", o_pdout, last_dout[v.sel]);
            din_drv = v.rx[k];
            tick();
            if (k > 0) begin
                check("tx_load_once", o_txl, 0);
                check("ready_low_shift", o_rdy, 0);
                check("state_shift_hold", o_st, 1);
            end
        end
        if (v.sel == 1'b0) begin
            check("state_par", o_st, 2);
            check("ready_low_par", o_rdy, 0);
            check("tx_parity", o_dout, v.txpar);
            check("word_held_par", o_pdout, last_dout[v.sel]);
            din_drv = v.par_bit;
            tick();
        end
        check("data_ready", o_rdy, 1);
        check("load_low_at_ready", o_txl, 0);
        check("rx_word", o_pdout, v.rx);
        check("parity_err", o_perr, v.perr);
        check("word_cnt", o_cnt, v.cnt);
        check("state_cont", o_st, 3);
        check("dout_cont", o_dout, 0);
        last_dout[v.sel] = v.rx;
        if (!v.cont) begin
            din_drv = 1'b0;
            tick();
            check("state_idle", o_st, 0);
            check("ready_one_cycle", o_rdy, 0);
            check("no_load_end", o_txl, 0);
            check("dout_idle", o_dout, 0);
            check("cnt_held", o_cnt, v.cnt);
            check("word_held_end", o_pdout, v.rx);
            check("perr_held", o_perr, v.perr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           sel   tx        rx        par   cont  txpar perr  cnt
        tbl[0]  = '{1'b0, 16'hF0FF, 16'hEAAF, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[1]  = '{1'b0, 16'hF0FF, 16'hEAAF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[2]  = '{1'b0, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[3]  = '{1'b0, 16'h1111, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[4]  = '{1'b0, 16'h2222, 16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        tbl[5]  = '{1'b0, 16'h3333, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
        tbl[6]  = '{1'b1, 16'h005A, 16'h00C3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[7]  = '{1'b1, 16'h0012, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[8]  = '{1'b1, 16'h0034, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        tbl[9]  = '{1'b1, 16'h0056, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
        tbl[10] = '{1'b1, 16'h0078, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3};
        tbl[11] = '{1'b1, 16'h009A, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
        last_dout[0] = 16'h0000;
        last_dout[1] = 16'h0000;

        // Power-on reset.
        bus_rst_n = 1'b0;
        tick();
        tick();
        select(0);
        check_zero("por_p");
        select(1);
        check_zero("por_n");
        bus_rst_n = 1'b1;

        // Idle noise: 20 edges of bus_din=0 on each instance.
        for (int s = 0; s < 2; s++) begin
            select(s);
            din_drv = 1'b0;
            for (int e = 0; e < 20; e++) begin
                tick();
                check("idle_state", o_st, 0);
                check("idle_ready", o_rdy, 0);
                check("idle_load", o_txl, 0);
                check("idle_dout", o_dout, 0);
            end
        end

        // Table-driven frames.
        for (int i = 0; i < 12; i++) begin
            run_word(tbl[i], (i == 0) || !tbl[i-1].cont);
        end

        // Reset in the middle of a frame: no partial delivery, all clean.
        select(0);
        pdin_drv = 16'hFFFF;
        din_drv  = 1'b1;
        tick();
        repeat (5) tick();
        check("pre_reset_shift", o_st, 1);
        bus_rst_n = 1'b0;
        tick();
        tick();
        din_drv   = 1'b0;
        bus_rst_n = 1'b1;
        check_zero("midrst");
        tick();
        check_zero("midrst_idle");
        last_dout[0] = 16'h0000;
        run_word(tbl[0], 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
